// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit adder split into STAGES equal chunks.
// Stage k adds chunk k of the operands using the carry registered out of
// stage k-1. Valid/ready handshakes on both sides with full backpressure.
// Optional feature macro: ADDER_OVF_EN adds the out_ovf signed-overflow output.
module pipe_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef ADDER_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    // Bits added per stage.
    localparam int C = WIDTH / STAGES;

    logic                         rdy_en;
    logic [STAGES-1:0]            v;
    logic [STAGES-1:0]            c;
    logic [STAGES-1:0]            adv;
    logic [STAGES-1:0][WIDTH-1:0] s;

    // Holds in_ready low during reset and until the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    // Advance chain: a stage may load when it is empty or everything after it moves.
    always_comb begin : p_adv
        logic run;
        adv = '0;
        run = out_ready | ~v[STAGES-1];
        adv[STAGES-1] = run;
        for (int k = STAGES - 2; k >= 0; k--) begin
            run    = run | ~v[k];
            adv[k] = run;
        end
    end

    assign in_ready = adv[0] & rdy_en;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // Operand bits still to be added when entering stage k; chunk k sits at [C-1:0].
        localparam int RW = WIDTH - k * C;

        logic [RW-1:0]    a_in;
        logic [RW-1:0]    b_in;
        logic             cin_in;
        logic             vin;
        logic [WIDTH-1:0] s_in;
        logic [C:0]       add;
        logic [WIDTH-1:0] s_next;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] s_q;

        if (k == 0) begin : g_first
            assign a_in   = in_a;
            assign b_in   = in_b;
            assign cin_in = in_cin;
            assign vin    = in_valid & rdy_en;
            assign s_in   = '0;
        end else begin : g_next
            assign a_in   = g_st[k-1].g_fwd.a_q;
            assign b_in   = g_st[k-1].g_fwd.b_q;
            assign cin_in = c[k-1];
            assign vin    = v[k-1];
            assign s_in   = s[k-1];
        end

        assign add = {1'b0, a_in[C-1:0]} + {1'b0, b_in[C-1:0]} + {{C{1'b0}}, cin_in};

        // Merge this chunk's sum into the partial sum carried from upstream.
        always_comb begin
            s_next          = s_in;
            s_next[k*C +: C] = add[C-1:0];
        end

        // Stage register: valid bit always follows the advance; data loads only with a valid entry.
        always_ff @(posedge clk or negedge rst_n) begin
            // NOTE: data registers are reset too so outputs read 0 during reset, not just the valid bit.
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv[k]) begin
                v_q <= vin;
                if (vin) begin
                    c_q <= add[C];
                    s_q <= s_next;
                end
            end
        end

        assign v[k] = v_q;
        assign c[k] = c_q;
        assign s[k] = s_q;

        if (k < STAGES - 1) begin : g_fwd
            logic [RW-C-1:0] a_q;
            logic [RW-C-1:0] b_q;

            // Forward the not-yet-added upper chunks of both operands.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv[k] && vin) begin
                    a_q <= a_in[RW-1:C];
                    b_q <= b_in[RW-1:C];
                end
            end
        end

`ifdef ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            // Carry into MSB is a^b^sum at the MSB; overflow is that XOR the carry out.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    ovf_q <= 1'b0;
                else if (adv[k] && vin)
                    ovf_q <= a_in[C-1] ^ b_in[C-1] ^ add[C-1] ^ add[C];
            end
        end
`endif
    end

    assign out_valid = v[STAGES-1];
    assign out_sum   = s[STAGES-1];
    assign out_cout  = c[STAGES-1];
`ifdef ADDER_OVF_EN
    assign out_ovf   = g_st[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Directed self-checking bench for pipe_adder (WIDTH=8, STAGES=2).
// Build with ADDER_OVF_EN defined to also exercise out_ovf.
module tb_pipe_adder;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef ADDER_OVF_EN
    logic             out_ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
`ifdef ADDER_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_a     = 'x;
        in_b     = 'x;
        in_cin   = 1'bx;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] sum, input logic cout);
        check({tag, " valid"}, out_valid, 1);
        check({tag, " sum"},   out_sum,   sum);
        check({tag, " cout"},  out_cout,  cout);
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        idle();

        // Reset state
        #3;
        check("rst out_valid", out_valid, 0);
        check("rst out_sum",   out_sum,   0);
        check("rst out_cout",  out_cout,  0);
        check("rst in_ready",  in_ready,  0);
`ifdef ADDER_OVF_EN
        check("rst out_ovf",   out_ovf,   0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-rst in_ready before clock", in_ready, 0);
        step();
        check("post-rst in_ready after clock", in_ready, 1);

        // 0xFF + 0x01: full wrap, carry out; latency STAGES-1 edges after accept
        out_ready = 1'b1;
        drive(8'hFF, 8'h01, 1'b0);
        step();
        idle();
        check("ff+01 not yet valid", out_valid, 0);
        step();
        expect_out("ff+01", 8'h00, 1'b1);
        step();
        check("ff+01 drained", out_valid, 0);

        // Chunk-boundary carry 0x0F + 0x00 + 1
        drive(8'h0F, 8'h00, 1'b1);
        step();
        idle();
        step();
        expect_out("0f+00+1", 8'h10, 1'b0);
        step();

        // Back-to-back, one result per cycle
        drive(8'h01, 8'h02, 1'b0);
        step();
        drive(8'h80, 8'h80, 1'b0);
        step();
        expect_out("b2b0", 8'h03, 1'b0);
        drive(8'h7F, 8'h01, 1'b0);
        step();
        expect_out("b2b1", 8'h00, 1'b1);
        drive(8'hAA, 8'h55, 1'b1);
        step();
        expect_out("b2b2", 8'h80, 1'b0);
        idle();
        step();
        expect_out("b2b3", 8'h00, 1'b1);
        step();
        check("b2b drained", out_valid, 0);

        // Backpressure: out_ready low while three inputs are offered
        out_ready = 1'b0;
        drive(8'h10, 8'h20, 1'b0);
        check("bp in_ready 1st", in_ready, 1);
        step();
        drive(8'hFE, 8'h03, 1'b0);
        check("bp in_ready 2nd", in_ready, 1);
        step();
        drive(8'h44, 8'h44, 1'b1);
        expect_out("bp head", 8'h30, 1'b0);
        check("bp in_ready full", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp stall sum",      out_sum,   8'h30);
            check("bp stall valid",    out_valid, 1);
            check("bp stall in_ready", in_ready,  0);
        end
        out_ready = 1'b1;
        #1;
        check("bp simultaneous in_ready", in_ready, 1);
        step();
        idle();
        expect_out("bp drain1", 8'h01, 1'b1);
        step();
        expect_out("bp drain2", 8'h89, 1'b0);
        step();
        check("bp drained", out_valid, 0);

        // Reset with two entries in flight
        out_ready = 1'b0;
        drive(8'h11, 8'h22, 1'b0);
        step();
        drive(8'h33, 8'h44, 1'b0);
        step();
        idle();
        check("mid pipe full", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst out_valid", out_valid, 0);
        check("mid rst out_sum",   out_sum,   0);
        check("mid rst in_ready",  in_ready,  0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("mid post-rst in_ready", in_ready, 1);
        check("mid post-rst no stale", out_valid, 0);
        out_ready = 1'b1;
        drive(8'h05, 8'h03, 1'b0);
        step();
        idle();
        check("mid new not yet valid", out_valid, 0);
        step();
        expect_out("mid 05+03", 8'h08, 1'b0);
        step();
        check("mid drained", out_valid, 0);

`ifdef ADDER_OVF_EN
        // Signed overflow
        drive(8'h7F, 8'h01, 1'b0);
        step();
        idle();
        step();
        expect_out("ovf 7f+01", 8'h80, 1'b0);
        check("ovf 7f+01 ovf", out_ovf, 1);
        drive(8'hFF, 8'h01, 1'b0);
        step();
        idle();
        step();
        expect_out("ovf ff+01", 8'h00, 1'b1);
        check("ovf ff+01 ovf", out_ovf, 0);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
